dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-ported data memory between two requesters:
  - port 0: the core load/store path.
  - port 1: a DMA/debug master.
- Accepts at most one request per cycle using valid/ready handshakes.
- Drives the memory's WE/A/WD/MemType directly and returns one registered response per accepted request, one cycle later.
- Round-robin fairness, optional owner lock for atomic multi-beat sequences, and a bounded lock length.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-ported data memory between two requesters.
//   Port 0 is the core load/store path, port 1 a DMA/debug master.
//   At most one request is accepted per cycle (valid/ready). Ties go
//   round-robin. A requester can lock ownership for atomic multi-beat
//   sequences, and the lock is bounded to MAX_LOCK beats. Every accepted
//   beat gets exactly one registered response on the next cycle.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rN_valid/ready    - request handshake (ready is combinational)
//   rN_addr/wdata     - byte address and store data
//   rN_we/type/lock   - store flag, access size, keep-ownership request
//   rN_rvalid/rdata   - response pulse and load data (0 for stores)
//   mem_we/addr/wd/type - memory drive; mem_rd - combinational read data
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [DATA_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic                  r0_we,
  input  logic                  r0_type,
  input  logic                  r0_lock,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [DATA_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic                  r1_we,
  input  logic                  r1_type,
  input  logic                  r1_lock,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_type,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [8:0]            cnt_inc;
  logic                  gnt_vld, gnt_sel, gnt_lock;
  logic                  rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_sel = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (r0_valid && r1_valid) begin
            gnt_vld = 1'b1;
            gnt_sel = ~last_q;
          end else if (r0_valid) begin
            gnt_vld = 1'b1;
          end else if (r1_valid) begin
            gnt_vld = 1'b1;
            gnt_sel = 1'b1;
          end
        end
        LOCK0:   gnt_vld = r0_valid;
        LOCK1: begin
          gnt_vld = r1_valid;
          gnt_sel = 1'b1;
        end
        default: gnt_vld = 1'b0;
      endcase
    end
  end

  assign r0_ready = gnt_vld & ~gnt_sel;
  assign r1_ready = gnt_vld &  gnt_sel;
  assign gnt_lock = gnt_sel ? r1_lock : r0_lock;
  assign cnt_inc  = {1'b0, cnt_q} + 9'd1;

  // Memory drive and next-state / response logic.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    mem_type = 1'b0;
    state_d  = state_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    if (gnt_vld) begin
      mem_we   = gnt_sel ? r1_we    : r0_we;
      mem_addr = gnt_sel ? r1_addr  : r0_addr;
      mem_wd   = gnt_sel ? r1_wdata : r0_wdata;
      mem_type = gnt_sel ? r1_type  : r0_type;
      last_d   = gnt_sel;
      // Reaching MAX_LOCK beats forces release even if lock is still asked.
      if (gnt_lock && (cnt_inc < 9'(MAX_LOCK))) begin
        state_d = gnt_sel ? LOCK1 : LOCK0;
        cnt_d   = cnt_inc[7:0];
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      if (gnt_sel) begin
        rv1_d = 1'b1;
        rd1_d = r1_we ? '0 : mem_rd;
      end else begin
        rv0_d = 1'b1;
        rd0_d = r0_we ? '0 : mem_rd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  // A response registered just before reset is masked so it is never seen.
  assign r0_rvalid = rv0_q & ~rst;
  assign r1_rvalid = rv1_q & ~rst;
  assign r0_rdata  = rst ? '0 : rd0_q;
  assign r1_rdata  = rst ? '0 : rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural reference model.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int ML = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v[2], we[2], ty[2], lk[2];
  logic [DW-1:0] ad[2], wd[2];
  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic          mem_we, mem_type;
  logic [DW-1:0] mem_addr, mem_wd, mem_rd;
  logic [DW-1:0] memv [16];

  assign mem_rd = memv[mem_addr[5:2]];

  dmem_arbiter #(.DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(v[0]), .r0_ready(rdy0), .r0_addr(ad[0]), .r0_wdata(wd[0]),
    .r0_we(we[0]), .r0_type(ty[0]), .r0_lock(lk[0]),
    .r0_rvalid(rv0), .r0_rdata(rd0),
    .r1_valid(v[1]), .r1_ready(rdy1), .r1_addr(ad[1]), .r1_wdata(wd[1]),
    .r1_we(we[1]), .r1_type(ty[1]), .r1_lock(lk[1]),
    .r1_rvalid(rv1), .r1_rdata(rd1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_type(mem_type), .mem_rd(mem_rd)
  );

  // Reference model: current owner (-1 = none), last granted port,
  // accepted beats under the current lock, and expected response outputs.
  int            m_owner = -1;
  int            m_last  = 1;
  int            m_cnt   = 0;
  logic          m_rv[2];
  logic [DW-1:0] m_rd[2];
  bit            acc[2];
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick();
    if (rst) return -1;
    if (m_owner >= 0) return v[m_owner] ? m_owner : -1;
    if (v[0] && v[1]) return 1 - m_last;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_cnt   = 0;
    for (int p = 0; p < 2; p++) begin
      m_rv[p] = 1'b0;
      m_rd[p] = '0;
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    int g;
    #4;
    g = pick();
    check("r0_ready", {31'b0, rdy0}, {31'b0, g == 0});
    check("r1_ready", {31'b0, rdy1}, {31'b0, g == 1});
    check("mem_we",   {31'b0, mem_we},   (g >= 0) ? {31'b0, we[g]} : '0);
    check("mem_addr", mem_addr,          (g >= 0) ? ad[g] : '0);
    check("mem_wd",   mem_wd,            (g >= 0) ? wd[g] : '0);
    check("mem_type", {31'b0, mem_type}, (g >= 0) ? {31'b0, ty[g]} : '0);
    check("r0_rvalid", {31'b0, rv0}, rst ? '0 : {31'b0, m_rv[0]});
    check("r1_rvalid", {31'b0, rv1}, rst ? '0 : {31'b0, m_rv[1]});
    check("r0_rdata",  rd0, rst ? '0 : m_rd[0]);
    check("r1_rdata",  rd1, rst ? '0 : m_rd[1]);
    @(posedge clk);
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      m_rv[0] = 1'b0;
      m_rv[1] = 1'b0;
      if (g >= 0) begin
        acc[g]  = 1'b1;
        m_rv[g] = 1'b1;
        m_rd[g] = we[g] ? '0 : memv[ad[g][5:2]];
        m_last  = g;
        if (lk[g] && (m_cnt + 1 < ML)) begin
          m_owner = g;
          m_cnt   = m_cnt + 1;
        end else begin
          m_owner = -1;
          m_cnt   = 0;
        end
      end
    end
    #1;
  endtask

  task automatic setp(input int p, input logic vv, input logic [DW-1:0] a,
                      input logic [DW-1:0] d, input logic w, input logic t,
                      input logic l);
    v[p]  = vv;
    ad[p] = a;
    wd[p] = d;
    we[p] = w;
    ty[p] = t;
    lk[p] = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) memv[i] = $urandom;
    memv[4] = 32'hDEADBEEF;
    model_reset();
    acc[0] = 1'b0;
    acc[1] = 1'b0;
    setp(0, 0, '0, '0, 0, 0, 0);
    setp(1, 0, '0, '0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_reset();

    // Single load on port 0.
    setp(0, 1, 32'h10, '0, 0, 1, 0);
    step();
    setp(0, 0, '0, '0, 0, 0, 0);
    step();

    // Tie round-robin, first grant to port 0 after reset.
    do_reset();
    setp(0, 1, 32'h20, 32'h111, 1, 0, 0);
    setp(1, 1, 32'h24, 32'h222, 0, 1, 0);
    repeat (4) step();
    setp(0, 0, '0, '0, 0, 0, 0);
    setp(1, 0, '0, '0, 0, 0, 0);
    step();

    // Port 1 locked store burst while port 0 waits.
    do_reset();
    setp(1, 1, 32'h30, 32'hA1, 1, 0, 1);
    step();
    setp(0, 1, 32'h34, '0, 0, 0, 0);
    setp(1, 1, 32'h38, 32'hA2, 1, 1, 1);
    step();
    setp(1, 1, 32'h3C, 32'hA3, 1, 0, 0);
    step();
    setp(1, 0, '0, '0, 0, 0, 0);
    step();
    setp(0, 0, '0, '0, 0, 0, 0);
    step();

    // Forced release after ML locked beats.
    do_reset();
    setp(0, 1, 32'h40, 32'hB0, 1, 0, 1);
    setp(1, 1, 32'h44, '0, 0, 0, 0);
    repeat (ML + 1) step();
    setp(0, 0, '0, '0, 0, 0, 0);
    setp(1, 0, '0, '0, 0, 0, 0);
    step();

    // Reset in the cycle after an accept drops the response.
    setp(0, 1, 32'h48, '0, 0, 0, 0);
    step();
    rst = 1'b1;
    setp(1, 1, 32'h4C, '0, 0, 1, 0);
    step();
    rst = 1'b0;
    step();
    setp(0, 0, '0, '0, 0, 0, 0);
    setp(1, 0, '0, '0, 0, 0, 0);
    step();

    // Idle owner keeps the lock.
    do_reset();
    setp(0, 1, 32'h50, 32'hC0, 1, 1, 1);
    step();
    setp(0, 0, '0, '0, 0, 0, 0);
    setp(1, 1, 32'h54, 32'hC1, 1, 0, 0);
    repeat (3) step();
    setp(0, 1, 32'h58, '0, 0, 0, 0);
    step();
    step();
    setp(0, 0, '0, '0, 0, 0, 0);
    setp(1, 0, '0, '0, 0, 0, 0);
    step();

    // Randomized traffic; requests are held until accepted.
    repeat (600) begin
      rst = ($urandom % 50) == 0;
      for (int p = 0; p < 2; p++) begin
        if (!v[p] || acc[p]) begin
          v[p]  = ($urandom % 10) < 6;
          ad[p] = $urandom;
          wd[p] = $urandom;
          we[p] = 1'($urandom);
          ty[p] = 1'($urandom);
          lk[p] = ($urandom % 3) != 0;
        end
      end
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
